// File: rtl/biquad8_coeff_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : biquad8_loader_pkg
//  Description : Shared types and constants for the biquad8 coefficient
//                loader. Holds the loader state encoding, the bit layout of
//                a coefficient-table entry and the update-strobe write that
//                is optionally appended after the last coefficient.
//  Revision    : 1.0 - initial release
// ============================================================================
package biquad8_loader_pkg;

    // ------------------------------------------------------------------------
    // Loader states
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LATCH  = 3'd2,
        ST_WRITE  = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // ------------------------------------------------------------------------
    // Coefficient-table entry layout (44 bits)
    //   [31:0]  data word
    //   [38:32] register byte address inside the channel window
    //   [42:39] byte lane select
    //   [43]    last entry of this load
    // ------------------------------------------------------------------------
    localparam int ENTRY_W  = 44;
    localparam int DAT_LSB  = 0;
    localparam int DAT_W    = 32;
    localparam int ADR_LSB  = 32;
    localparam int ADR_W    = 7;
    localparam int SEL_LSB  = 39;
    localparam int SEL_W    = 4;
    localparam int LAST_BIT = 43;

    // Word index inside the 7-bit register window (byte address bits [6:2]).
    localparam int WORD_W   = ADR_W - 2;

    // ------------------------------------------------------------------------
    // Update-strobe write: control register, bit 0 only. Lane 2 stays clear
    // so the bypass field of the control register is left untouched.
    // ------------------------------------------------------------------------
    localparam logic [ADR_W-1:0] UPDATE_ADR = 7'h00;
    localparam logic [DAT_W-1:0] UPDATE_DAT = 32'h1;
    localparam logic [SEL_W-1:0] UPDATE_SEL = 4'b0001;

    // Word index of an entry's register address; the two byte-offset bits
    // are dropped because every write is a full 32-bit word slot.
    function automatic logic [WORD_W-1:0] entry_word(input logic [ENTRY_W-1:0] entry);
        return entry[ADR_LSB+2 +: WORD_W];
    endfunction

endpackage : biquad8_loader_pkg
`default_nettype wire

// File: rtl/biquad8_coeff_loader.sv
`default_nettype none
// ============================================================================
//  Module      : biquad8_coeff_loader
//  Description : WISHBONE master that programs one biquad8 channel from a
//                coefficient table. On start_i it walks table entries from
//                base_i, issues one single-beat write per entry into the
//                selected channel's 7-bit register window and optionally
//                finishes with the update-strobe write.
//
//  Ports
//    wb_clk_i / wb_rst_i     clock, synchronous active-high reset
//    start_i / abort_i       begin a load / terminate a load
//    chan_i, base_i,         channel, first table address and update-append
//    auto_update_i           flag, all captured when a start is accepted
//    tbl_adr_o / tbl_dat_i   table RAM read port (1-cycle read latency)
//    wbm_*                   WISHBONE master, single-beat writes only
//    busy_o                  high from FETCH through DONE
//    done_o                  one-cycle completion pulse
//    err_o                   sticky error, cleared by the next accepted start
//    count_o                 writes acknowledged in the current/last load
//
//  Revision    : 1.0 - initial release
// ============================================================================
module biquad8_coeff_loader
    import biquad8_loader_pkg::*;
#(
    parameter int NCHAN        = 16,
    parameter int CHAN_BITS    = $clog2(NCHAN),
    parameter int TBL_ADR_BITS = 10,
    parameter int MAX_ENTRIES  = 64,
    parameter int TIMEOUT      = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,

    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [CHAN_BITS-1:0]      chan_i,
    input  logic [TBL_ADR_BITS-1:0]   base_i,
    input  logic                      auto_update_i,

    output logic [TBL_ADR_BITS-1:0]   tbl_adr_o,
    input  logic [ENTRY_W-1:0]        tbl_dat_i,

    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    output logic                      wbm_we_o,
    output logic [ADR_W+CHAN_BITS-1:0] wbm_adr_o,
    output logic [DAT_W-1:0]          wbm_dat_o,
    output logic [SEL_W-1:0]          wbm_sel_o,
    input  logic                      wbm_ack_i,
    input  logic                      wbm_err_i,

    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [6:0]                count_o
);

    localparam int ENT_W = $clog2(MAX_ENTRIES + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    // ------------------------------------------------------------------------
    // State and captured load parameters
    // ------------------------------------------------------------------------
    state_e                     state_q;
    logic [CHAN_BITS-1:0]       chan_q;
    logic                       auto_upd_q;
    logic                       last_q;
    logic [ENT_W-1:0]           entries_q;
    logic [TMO_W-1:0]           tmo_q;
    logic                       gap_q;

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    logic [TBL_ADR_BITS-1:0]    tbl_adr_q;
    logic                       cyc_q;
    logic [ADR_W+CHAN_BITS-1:0] adr_q;
    logic [DAT_W-1:0]           dat_q;
    logic [SEL_W-1:0]           sel_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       err_q;
    logic [6:0]                 count_q;

    // ------------------------------------------------------------------------
    // Bus response decode. Only meaningful while a cycle is open; err has
    // priority over ack, and a timeout is only declared with neither present.
    // ------------------------------------------------------------------------
    logic w_bus_err;
    logic w_bus_ack;
    logic w_timeout;
    logic w_max_hit;
    logic w_bad_chan;

    assign w_bus_err  = cyc_q & wbm_err_i;
    assign w_bus_ack  = cyc_q & wbm_ack_i & ~wbm_err_i;
    assign w_timeout  = cyc_q & ~wbm_ack_i & ~wbm_err_i & (tmo_q == TMO_W'(TIMEOUT));
    assign w_max_hit  = (entries_q == ENT_W'(MAX_ENTRIES));

    // Extended by one bit so NCHAN == 2**CHAN_BITS still compares correctly.
    assign w_bad_chan = ({1'b0, chan_i} >= (CHAN_BITS+1)'(NCHAN));

    // The byte-offset bits of the entry address are never used.
    logic w_unused_adr_lsbs;
    assign w_unused_adr_lsbs = ^tbl_dat_i[ADR_LSB +: 2];

    // ------------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            chan_q     <= '0;
            auto_upd_q <= 1'b0;
            last_q     <= 1'b0;
            entries_q  <= '0;
            tmo_q      <= '0;
            gap_q      <= 1'b0;
            tbl_adr_q  <= '0;
            cyc_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
        end else begin
            done_q <= 1'b0;

            if (state_q == ST_IDLE) begin
                // abort_i takes precedence over a simultaneous start_i.
                if (start_i && !abort_i) begin
                    chan_q     <= chan_i;
                    auto_upd_q <= auto_update_i;
                    tbl_adr_q  <= base_i;
                    entries_q  <= '0;
                    count_q    <= '0;
                    busy_q     <= 1'b1;
                    if (w_bad_chan) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        err_q   <= 1'b0;
                        state_q <= ST_FETCH;
                    end
                end
            end else begin
                // An ack arriving together with an abort is still counted.
                if (w_bus_ack) begin
                    count_q <= count_q + 7'd1;
                end

                if (abort_i && state_q != ST_DONE) begin
                    cyc_q   <= 1'b0;
                    err_q   <= 1'b1;
                    state_q <= ST_DONE;
                end else begin
                    case (state_q)
                        ST_FETCH: begin
                            // Table RAM is reading tbl_adr_q this cycle.
                            state_q <= ST_LATCH;
                        end

                        ST_LATCH: begin
                            adr_q     <= {chan_q, entry_word(tbl_dat_i), 2'b00};
                            dat_q     <= tbl_dat_i[DAT_LSB +: DAT_W];
                            sel_q     <= tbl_dat_i[SEL_LSB +: SEL_W];
                            last_q    <= tbl_dat_i[LAST_BIT];
                            entries_q <= entries_q + ENT_W'(1);
                            tmo_q     <= '0;
                            cyc_q     <= 1'b1;
                            state_q   <= ST_WRITE;
                        end

                        ST_WRITE: begin
                            if (w_bus_err || w_timeout) begin
                                cyc_q   <= 1'b0;
                                err_q   <= 1'b1;
                                state_q <= ST_DONE;
                            end else if (w_bus_ack) begin
                                cyc_q <= 1'b0;
                                if (last_q || w_max_hit) begin
                                    if (!last_q) begin
                                        // Ran out of entries without a last
                                        // marker: the set is incomplete, so
                                        // it must not be committed.
                                        err_q   <= 1'b1;
                                        state_q <= ST_DONE;
                                    end else if (auto_upd_q) begin
                                        adr_q   <= {chan_q, UPDATE_ADR};
                                        dat_q   <= UPDATE_DAT;
                                        sel_q   <= UPDATE_SEL;
                                        gap_q   <= 1'b0;
                                        state_q <= ST_UPDATE;
                                    end else begin
                                        state_q <= ST_DONE;
                                    end
                                end else begin
                                    tbl_adr_q <= tbl_adr_q + TBL_ADR_BITS'(1);
                                    state_q   <= ST_FETCH;
                                end
                            end else begin
                                tmo_q <= tmo_q + TMO_W'(1);
                            end
                        end

                        ST_UPDATE: begin
                            if (!cyc_q) begin
                                // Hold cyc low for two cycles after the last
                                // coefficient write, matching the gap that
                                // FETCH/LATCH give between ordinary writes.
                                if (gap_q) begin
                                    tmo_q <= '0;
                                    cyc_q <= 1'b1;
                                end else begin
                                    gap_q <= 1'b1;
                                end
                            end else if (w_bus_err || w_timeout) begin
                                cyc_q   <= 1'b0;
                                err_q   <= 1'b1;
                                state_q <= ST_DONE;
                            end else if (w_bus_ack) begin
                                cyc_q   <= 1'b0;
                                state_q <= ST_DONE;
                            end else begin
                                tmo_q <= tmo_q + TMO_W'(1);
                            end
                        end

                        ST_DONE: begin
                            if (abort_i) begin
                                err_q <= 1'b1;
                            end
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end

                        default: begin
                            cyc_q   <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign tbl_adr_o = tbl_adr_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = cyc_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign count_o   = count_q;

endmodule : biquad8_coeff_loader
`default_nettype wire
